channel_scan_mux: RTL

Parametrised, registered N-channel, W-bit multiplexer with two modes. In manual mode the caller chooses the channel. In scan mode the block walks all channels round-robin and holds each one for a programmable dwell time. Every result is presented on a valid/ready output handshake. It replaces the fixed 6-to-1 single-bit selector in board-level datapaths that need wider channels, timed sampling and flow control.

---
 rtl/mux_pkg.sv | 14 +
 rtl/dwell_counter.sv | 33 +++
 rtl/channel_scan_mux.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the channel scan multiplexer: FSM state encoding
// and the mode constants that select manual or scan operation.
package mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DWELL = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer for the scan multiplexer. Counts up while enabled and flags
// when the programmed terminal value (effective dwell minus one) is reached.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clear,
    input  logic                                      count_en,
    input  logic [((DWELL > 1) ? $clog2(DWELL) : 1)-1:0] terminal,
    output logic                                      done
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] count;

    // Count cycles spent dwelling; clear restarts the next dwell from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 1'b1;
        end
    end

    // ">=" rather than "==" so a switch to a shorter dwell mid-count
    // still reaches a capture decision instead of wrapping the counter.
    always_comb begin
        done = (count >= terminal);
    end

endmodule

// File: rtl/channel_scan_mux.sv
// Registered N-channel, WIDTH-bit multiplexer with manual and scan modes.
// Results leave on a valid/ready handshake: a sample is transferred on a
// rising edge where OutValid and OutReady are both high; once OutValid is
// raised the sample and its tags stay frozen until that transfer happens.
// dbg_state and dbg_ptr expose the FSM state and scan pointer.
module channel_scan_mux
    import mux_pkg::*;
#(
    parameter int N_CH  = 6,
    parameter int WIDTH = 1,
    parameter int DWELL = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [N_CH*WIDTH-1:0]   Input,
    input  logic [SEL_W-1:0]        MuxSelect,
    input  logic                    Mode,
    input  logic                    Enable,
    input  logic                    OutReady,
    output logic [WIDTH-1:0]        Out,
    output logic                    OutValid,
    output logic [SEL_W-1:0]        CurSel,
    output logic                    SelError,
    output logic [1:0]              dbg_state,
    output logic [SEL_W-1:0]        dbg_ptr
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] terminal;
    logic             done;
    logic             cnt_en;
    logic             cnt_clear;
    logic [SEL_W-1:0] src;
    logic             src_bad;
    logic [WIDTH-1:0] chan_data;

    // Effective dwell follows the live Mode input on every dwell cycle.
    always_comb begin
        terminal = (Mode == MODE_SCAN) ? CNT_W'(DWELL - 1) : '0;
    end

    // The counter only runs inside DWELL; any other situation rearms it at zero.
    always_comb begin
        cnt_en    = (state == ST_DWELL) && Enable && !done;
        cnt_clear = !cnt_en;
    end

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell_counter (
        .clk     (Clock),
        .rst     (Reset),
        .clear   (cnt_clear),
        .count_en(cnt_en),
        .terminal(terminal),
        .done    (done)
    );

    // Source channel selection and slice; out-of-range selects read as zero.
    always_comb begin
        src       = (Mode == MODE_SCAN) ? ptr : MuxSelect;
        src_bad   = (int'(src) >= N_CH);
        chan_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (src == SEL_W'(k)) begin
                chan_data = Input[k*WIDTH +: WIDTH];
            end
        end
    end

    // Main FSM: owns the scan pointer and every registered output.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            Out      <= '0;
            OutValid <= 1'b0;
            CurSel   <= '0;
            SelError <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Enable) begin
                        state <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (!Enable) begin
                        state <= ST_IDLE;
                    end else if (done) begin
                        Out      <= chan_data;
                        CurSel   <= src;
                        SelError <= src_bad;
                        OutValid <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        if (Mode == MODE_SCAN) begin
                            ptr <= (ptr == SEL_W'(N_CH - 1)) ? '0 : ptr + 1'b1;
                        end
                        state <= Enable ? ST_DWELL : ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

    // Debug taps straight from the state registers.
    always_comb begin
        dbg_state = state;
        dbg_ptr   = ptr;
    end

endmodule
